// File: rtl/fir_pkg.sv
// Shared types, widths and helpers for the time-multiplexed symmetric FIR.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Address width that never collapses to zero bits.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (clog2(depth) == 0) ? 1 : clog2(depth);
  endfunction

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_COEF_W = 18;
  localparam int unsigned DEF_TAPS   = 102;

  localparam int unsigned PRE_W  = DEF_DATA_W + 1;
  localparam int unsigned PROD_W = DEF_DATA_W + DEF_COEF_W + 1;
  localparam int unsigned ACC_W  = PROD_W + clog2(DEF_TAPS / 2);

endpackage

// File: rtl/fir_coef_ram.sv
// H x COEF_W coefficient register file: one write port, async read, cleared on reset.
module fir_coef_ram
  import fir_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned COEF_W = 18,
  parameter int unsigned AW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [COEF_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [COEF_W-1:0] rdata
);

  logic [COEF_W-1:0] mem_q [DEPTH];
  logic [COEF_W-1:0] mem_d [DEPTH];

  // Out-of-range addresses match no entry, so they are silently dropped.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (we && (waddr == AW'(i))) mem_d[i] = wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (raddr == AW'(i)) rdata = mem_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/fir_symm_tdm.sv
// Even-length symmetric FIR sharing one multiplier across H = TAPS/2 coefficient slots,
// with valid/ready input, round-half-up scaling, saturation and synchronous clear.
module fir_symm_tdm
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned COEF_W    = DEF_COEF_W,
  parameter int unsigned TAPS      = DEF_TAPS,
  parameter int unsigned OUT_SHIFT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          coef_we,
  input  logic [addr_w(TAPS/2)-1:0]     coef_addr,
  input  logic [COEF_W-1:0]             coef_wdata,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_sat
);

  localparam int unsigned H     = TAPS / 2;
  localparam int unsigned AW    = addr_w(H);
  localparam int unsigned SUM_W = DATA_W + 1;
  localparam int unsigned MUL_W = DATA_W + COEF_W + 1;
  localparam int unsigned AC_W  = MUL_W + clog2(H);

  localparam logic signed [AC_W:0]   RND_C  = (AC_W+1)'(1) << (OUT_SHIFT - 1);
  localparam logic signed [AC_W:0]   SAT_MX = (AC_W+1)'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [AC_W:0]   SAT_MN = ~SAT_MX;
  localparam logic [DATA_W-1:0]      OUT_MX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]      OUT_MN = {1'b1, {(DATA_W-1){1'b0}}};

  state_e                    state_q, state_d;
  logic [AW-1:0]             idx_q, idx_d;
  logic signed [AC_W-1:0]    acc_q, acc_d;
  logic signed [DATA_W-1:0]  x_q [TAPS];
  logic signed [DATA_W-1:0]  x_d [TAPS];
  logic                      out_valid_q, out_valid_d;
  logic [DATA_W-1:0]         out_data_q, out_data_d;
  logic                      out_sat_q, out_sat_d;

  logic                      accept;
  logic                      coef_wr;
  logic [COEF_W-1:0]         coef_rd;
  logic signed [DATA_W-1:0]  tap_a, tap_b;
  logic signed [SUM_W-1:0]   pre_sum;
  logic signed [MUL_W-1:0]   pre_ext, coef_ext, prod;
  logic signed [AC_W:0]      rnd_sum, shifted;
  logic                      sat_hi, sat_lo;

  assign in_ready  = (state_q == ST_IDLE) && !clear && !rst;
  assign accept    = in_valid && in_ready;
  assign coef_wr   = coef_we && (state_q == ST_IDLE) && !clear;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  fir_coef_ram #(
    .DEPTH  (H),
    .COEF_W (COEF_W),
    .AW     (AW)
  ) u_coef_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (coef_wr),
    .waddr (coef_addr),
    .wdata (coef_wdata),
    .raddr (idx_q),
    .rdata (coef_rd)
  );

  // Symmetric pair for the current slot: x[idx] and its mirror x[TAPS-1-idx].
  always_comb begin
    tap_a = '0;
    tap_b = '0;
    for (int unsigned i = 0; i < H; i++) begin
      if (idx_q == AW'(i)) begin
        tap_a = x_q[i];
        tap_b = x_q[TAPS-1-i];
      end
    end
    pre_sum  = SUM_W'(tap_a) + SUM_W'(tap_b);
    pre_ext  = MUL_W'(pre_sum);
    coef_ext = MUL_W'($signed(coef_rd));
    prod     = pre_ext * coef_ext;
  end

  always_comb begin
    rnd_sum = (AC_W+1)'(acc_q) + RND_C;
    shifted = rnd_sum >>> OUT_SHIFT;
    sat_hi  = shifted > SAT_MX;
    sat_lo  = shifted < SAT_MN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = ST_MAC;
        ST_MAC:  if (idx_q == AW'(H - 1)) state_d = ST_OUT;
        ST_OUT:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    x_d         = x_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (clear) begin
      for (int unsigned i = 0; i < TAPS; i++) x_d[i] = '0;
      idx_d = '0;
      acc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            x_d[0] = $signed(in_data);
            for (int unsigned i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
            idx_d = '0;
            acc_d = '0;
          end
        end
        ST_MAC: begin
          acc_d = acc_q + AC_W'(prod);
          idx_d = idx_q + AW'(1);
        end
        ST_OUT: begin
          out_valid_d = 1'b1;
          out_sat_d   = sat_hi || sat_lo;
          if (sat_hi)      out_data_d = OUT_MX;
          else if (sat_lo) out_data_d = OUT_MN;
          else             out_data_d = DATA_W'(shifted);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) x_q[i] <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      x_q         <= x_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_fir_symm_tdm.sv
// Bench for fir_symm_tdm: two instances (OUT_SHIFT 1 and 2) share stimulus and are
// checked every cycle against a sample-level model, plus literal response tables.
module tb_fir_symm_tdm;

  localparam int TAPS = 8;
  localparam int H    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_addr = '0;
  logic [17:0] coef_wdata = '0;
  logic        in_ready1, in_ready2, out_valid1, out_valid2, out_sat1, out_sat2;
  logic [15:0] out_data1, out_data2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_symm_tdm #(.DATA_W(16), .COEF_W(18), .TAPS(TAPS), .OUT_SHIFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(out_valid1), .out_data(out_data1), .out_sat(out_sat1));

  fir_symm_tdm #(.DATA_W(16), .COEF_W(18), .TAPS(TAPS), .OUT_SHIFT(2)) u_dut2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(out_valid2), .out_data(out_data2), .out_sat(out_sat2));

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int  hist [TAPS];
  int  mcoef [H];
  int  m_busy = 0;
  bit  m_ov = 1'b0;
  int  m_od [2] = '{0, 0};
  bit  m_os [2] = '{1'b0, 1'b0};
  int  m_pd [2] = '{0, 0};
  bit  m_ps [2] = '{1'b0, 1'b0};
  int  m_accepts = 0;

  function automatic void filt(input int shift, output int r, output bit s);
    longint acc, v;
    acc = 0;
    for (int k = 0; k < H; k++)
      acc += longint'(hist[k] + hist[TAPS-1-k]) * longint'(mcoef[k]);
    v = (acc + (longint'(1) <<< (shift - 1))) >>> shift;
    s = 1'b0;
    if (v > 32767)       begin v = 32767;  s = 1'b1; end
    else if (v < -32768) begin v = -32768; s = 1'b1; end
    r = int'(v);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) hist[i] = 0;
      for (int i = 0; i < H; i++) mcoef[i] = 0;
      m_busy = 0; m_ov = 1'b0;
      m_od = '{0, 0}; m_os = '{1'b0, 1'b0};
    end else if (clear) begin
      for (int i = 0; i < TAPS; i++) hist[i] = 0;
      m_busy = 0; m_ov = 1'b0;
    end else begin
      m_ov = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_ov = 1'b1; m_od = m_pd; m_os = m_ps;
        end
      end else begin
        if (coef_we) mcoef[coef_addr] = int'($signed(coef_wdata));
        if (in_valid) begin
          for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
          hist[0] = int'($signed(in_data));
          filt(1, m_pd[0], m_ps[0]);
          filt(2, m_pd[1], m_ps[1]);
          m_busy = H + 1;
          m_accepts++;
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge clk) begin
    bit exp_ready;
    exp_ready = !rst && !clear && (m_busy == 0);
    chk("in_ready1", in_ready1, exp_ready);
    chk("in_ready2", in_ready2, exp_ready);
    chk("out_valid1", out_valid1, m_ov);
    chk("out_valid2", out_valid2, m_ov);
    chk("out_data1", $signed(out_data1), m_od[0]);
    chk("out_data2", $signed(out_data2), m_od[1]);
    chk("out_sat1", out_sat1, m_os[0]);
    chk("out_sat2", out_sat2, m_os[1]);
  end

  int q1[$], q2[$], s1[$];
  always @(negedge clk) begin
    if (!rst && out_valid1) begin q1.push_back(int'($signed(out_data1))); s1.push_back(int'(out_sat1)); end
    if (!rst && out_valid2) q2.push_back(int'($signed(out_data2)));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy != 0 && n < 20) begin tick(); n++; end
    if (m_busy != 0) begin
      n_err++;
      $display("FAIL idle_timeout: model still busy after %0d cycles", n);
    end
  endtask

  task automatic write_coef(input int k, input int v);
    wait_idle();
    coef_we = 1'b1; coef_addr = 2'(k); coef_wdata = 18'(v);
    tick();
    coef_we = 1'b0;
  endtask

  task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
    write_coef(0, c0); write_coef(1, c1); write_coef(2, c2); write_coef(3, c3);
  endtask

  task automatic send(input int v);
    wait_idle();
    in_valid = 1'b1; in_data = 16'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    wait_idle(); tick(); tick();
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic flush_q();
    q1.delete(); q2.delete(); s1.delete();
  endtask

  task automatic check_seq(input string nm, input int got[$], input int exp[$]);
    chk({nm, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) chk(nm, got[i], exp[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int e[$];
    int acc0;

    repeat (2) tick();
    chk("rst_in_ready", in_ready1, 0);
    chk("rst_out_valid", out_valid1, 0);
    chk("rst_out_data", out_data1, 0);
    rst = 1'b0;
    tick();

    // Impulse response
    set_coefs(2, 4, 6, 8);
    flush_q();
    send(100);
    repeat (15) send(0);
    drain();
    e = '{100, 200, 300, 400, 400, 300, 200, 100, 0, 0, 0, 0, 0, 0, 0, 0};
    check_seq("impulse_s1", q1, e);
    e = '{50, 100, 150, 200, 200, 150, 100, 50, 0, 0, 0, 0, 0, 0, 0, 0};
    check_seq("impulse_s2", q2, e);

    // Round half up
    set_coefs(1, 0, 0, 0);
    flush_q();
    send(6); send(-6); send(5);
    drain();
    e = '{2, -1, 1};
    check_seq("round_s2", q2, e);
    e = '{3, -3, 3};
    check_seq("round_s1", q1, e);

    // Saturation at both rails, then a result exactly at the positive rail
    do_clear();
    set_coefs(131071, 0, 0, 0);
    flush_q();
    send(32767); send(-32768);
    drain();
    e = '{32767, -32768};
    check_seq("sat_s1", q1, e);
    check_seq("sat_s2", q2, e);
    e = '{1, 1};
    check_seq("sat_flag_s1", s1, e);
    do_clear();
    write_coef(0, 65533);
    flush_q();
    send(1);
    drain();
    e = '{32767};
    check_seq("edge_s1", q1, e);
    e = '{0};
    check_seq("edge_flag_s1", s1, e);
    e = '{16383};
    check_seq("edge_s2", q2, e);

    // Coefficient write during MAC is dropped
    do_clear();
    set_coefs(2, 4, 6, 8);
    flush_q();
    send(100);
    coef_we = 1'b1; coef_addr = 2'd0; coef_wdata = 18'd1000;
    tick();
    coef_we = 1'b0;
    drain();
    send(0);
    drain();
    e = '{100, 200};
    check_seq("coef_in_mac", q1, e);

    // in_valid held high: one accept per computation
    wait_idle();
    flush_q();
    acc0 = m_accepts;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      in_data = 16'($urandom);
      coef_we = 1'($urandom); coef_addr = 2'($urandom); coef_wdata = 18'($urandom_range(0, 255));
      tick();
    end
    in_valid = 1'b0; coef_we = 1'b0;
    drain();
    chk("held_accepts", m_accepts - acc0, 10);
    chk("held_outputs", q1.size(), m_accepts - acc0);

    // Clear in the middle of MAC
    do_clear();
    set_coefs(2, 4, 6, 8);
    flush_q();
    send(100);
    tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    chk("ready_after_clear", in_ready1, 1);
    repeat (8) tick();
    chk("clear_no_output", q1.size(), 0);
    send(100);
    repeat (7) send(0);
    drain();
    e = '{100, 200, 300, 400, 400, 300, 200, 100};
    check_seq("post_clear", q1, e);

    // Asynchronous reset mid-MAC
    send(100);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid1, 0);
    chk("arst_out_data", out_data1, 0);
    chk("arst_out_sat", out_sat1, 0);
    chk("arst_in_ready", in_ready1, 0);
    chk("arst_out_data2", out_data2, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    flush_q();
    send(100);
    repeat (7) send(0);
    drain();
    e = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_seq("post_reset", q1, e);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid   = 1'($urandom);
      in_data    = 16'($urandom);
      coef_we    = ($urandom_range(0, 3) == 0);
      coef_addr  = 2'($urandom);
      coef_wdata = 18'($urandom);
      clear      = ($urandom_range(0, 39) == 0);
      tick();
    end
    in_valid = 1'b0; coef_we = 1'b0; clear = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
